// File: rtl/popcnt_seq.sv
// popcnt_seq -- multi-cycle population counter for wide vectors.
//
// One W-bit vector is accepted on a valid/ready input.  A single CHUNK_W-bit
// popcount datapath is then reused over the vector, one chunk per clock, and
// the accumulated total is returned on a valid/ready output.  Counting stops
// early once no set bits remain above the chunk just processed.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous, active-high reset
//   in_vld   input vector valid
//   in_dat   input vector (W bits), sampled only on in_vld & in_rdy
//   in_rdy   block can accept a vector (IDLE and not in reset)
//   out_vld  result valid, held until out_rdy
//   out_cnt  population count of the accepted vector ($clog2(W)+1 bits)
//   out_rdy  consumer accepts the result
//   busy     high whenever the block is not IDLE
module popcnt_seq #(
  parameter int W       = 64,
  parameter int CHUNK_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [W-1:0]         in_dat,
  output logic                 in_rdy,
  output logic                 out_vld,
  output logic [$clog2(W):0]   out_cnt,
  input  logic                 out_rdy,
  output logic                 busy
);

  localparam int N_CHUNKS = W / CHUNK_W;
  localparam int CW       = $clog2(W) + 1;
  localparam int PW       = $clog2(CHUNK_W) + 1;
  localparam int IW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CHUNKS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  if (CHUNK_W < 1 || (W % CHUNK_W) != 0) begin : g_bad_params
    $error("popcnt_seq: W must be a positive multiple of CHUNK_W");
  end

  logic [1:0]    state;
  logic [W-1:0]  sh;
  logic [CW-1:0] acc;
  logic [IW-1:0] idx;

  logic [PW-1:0] pc;
  logic [W-1:0]  sh_next;
  logic          last;

  // Shared chunk datapath: popcount of the low chunk of the shift register.
  always_comb begin
    pc = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pc = pc + PW'(sh[i]);
    end
  end

  // Early exit once nothing above the current chunk is set, or on the final
  // chunk. With N_CHUNKS==1 the shift empties the register so COUNT is one cycle.
  always_comb begin
    sh_next = sh >> CHUNK_W;
    last    = (sh_next == '0) || (idx == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld && in_rdy) begin
            sh    <= in_dat;
            acc   <= '0;
            idx   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          acc <= acc + CW'(pc);
          sh  <= sh_next;
          idx <= idx + 1'b1;
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_rdy is gated by rst so nothing is accepted while reset is held.
  assign in_rdy  = (state == IDLE) && !rst;
  assign out_vld = (state == DONE);
  assign out_cnt = acc;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_popcnt_seq.sv
// tb_popcnt_seq -- self-checking bench for popcnt_seq (W=64, CHUNK_W=8).
//
// A queue-based model records each accepted vector together with its
// population count and the cycle its result is due (handshake cycle + k + 2,
// k being the highest chunk holding a set bit).  A monitor compares busy,
// in_rdy, out_vld and out_cnt against that model on every cycle, while the
// directed sequences pin latency and count to hand-computed literals.
module tb_popcnt_seq;

  localparam int W       = 64;
  localparam int CHUNK_W = 8;
  localparam int NC      = W / CHUNK_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic [W-1:0]  in_dat = '0;
  logic          in_rdy;
  logic          out_vld;
  logic [$clog2(W):0] out_cnt;
  logic          out_rdy = 1'b0;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_done   = 0;

  typedef struct {
    int cnt;
    int due;
  } exp_t;

  exp_t q[$];

  popcnt_seq #(.W(W), .CHUNK_W(CHUNK_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_cnt (out_cnt),
    .out_rdy (out_rdy),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval between rising edges n and n+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int highChunk(input logic [W-1:0] v);
    int k = 0;
    for (int i = 0; i < NC; i++) begin
      if (((v >> (CHUNK_W * i)) & {{(W-CHUNK_W){1'b0}}, {CHUNK_W{1'b1}}}) != '0) k = i;
    end
    return k;
  endfunction

  // Per-cycle comparison against the queue model.  Checks are made before the
  // handshakes of this cycle update the model, since those take effect at the
  // next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      exp_t e;
      bit exp_vld;
      checkOutput("busy", int'(busy), int'(q.size() > 0));
      checkOutput("in_rdy", int'(in_rdy), int'(q.size() == 0));
      exp_vld = (q.size() > 0) && (cyc >= q[0].due);
      checkOutput("out_vld", int'(out_vld), int'(exp_vld));
      if (out_vld && q.size() > 0) begin
        checkOutput("out_cnt", int'(out_cnt), q[0].cnt);
        if (out_rdy) begin
          void'(q.pop_front());
          n_done++;
        end
      end
      if (in_vld && in_rdy) begin
        e.cnt = $countones(in_dat);
        e.due = cyc + highChunk(in_dat) + 2;
        q.push_back(e);
      end
    end
  end

  // Sends one vector, measures cycles from handshake to out_vld, and checks
  // latency and count against literals.  stall>0 holds out_rdy low that many
  // cycles after out_vld rises.
  task automatic applyStimulus(input string name, input logic [W-1:0] v,
                               input int exp_lat, input int exp_cnt, input int stall);
    int h;
    int lat;
    bit got;
    @(posedge clk); #1;
    in_vld  = 1'b1;
    in_dat  = v;
    out_rdy = (stall == 0);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_rdy) got = 1'b1;
    end
    if (!got) begin
      checkOutput({name, "_accept_timeout"}, 0, 1);
      in_vld = 1'b0;
      return;
    end
    h = cyc;
    @(posedge clk); #1;
    in_vld = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_vld) got = 1'b1;
    end
    if (!got) begin
      checkOutput({name, "_result_timeout"}, 0, 1);
      out_rdy = 1'b1;
      return;
    end
    lat = cyc - h;
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_cnt"}, int'(out_cnt), exp_cnt);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checkOutput({name, "_stall_vld"}, int'(out_vld), 1);
        checkOutput({name, "_stall_cnt"}, int'(out_cnt), exp_cnt);
        checkOutput({name, "_stall_in_rdy"}, int'(in_rdy), 0);
      end
      @(posedge clk); #1;
      out_rdy = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    checkOutput({name, "_vld_drop"}, int'(out_vld), 0);
    checkOutput({name, "_in_rdy_back"}, int'(in_rdy), 1);
  endtask

  initial begin
    int h;
    int target;
    int sh;
    logic [W-1:0] r;

    // Reset state while rst is held.
    #12;
    checkOutput("rst_in_rdy", int'(in_rdy), 0);
    checkOutput("rst_out_vld", int'(out_vld), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_cnt", int'(out_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rel_in_rdy", int'(in_rdy), 1);

    // Directed vectors with hand-computed latency and count.
    applyStimulus("ones",    64'hFFFF_FFFF_FFFF_FFFF, 9, 64, 0);
    applyStimulus("one",     64'h1,                   2, 1,  0);
    applyStimulus("zero",    64'h0,                   2, 0,  0);
    applyStimulus("ends",    64'h8000_0000_0000_0001, 9, 2,  0);
    applyStimulus("mid",     64'h0000_0000_00F0_0F00, 4, 8,  0);
    applyStimulus("stall",   64'h0000_00FF_0000_0101, 6, 10, 5);

    // Reset in the fourth cycle of an all-ones count.
    @(posedge clk); #1;
    in_vld = 1'b1;
    in_dat = '1;
    out_rdy = 1'b1;
    h = -1;
    for (int i = 0; i < 50 && h < 0; i++) begin
      @(negedge clk);
      if (in_rdy) h = cyc;
    end
    if (h < 0) checkOutput("abort_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_vld", int'(out_vld), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_in_rdy", int'(in_rdy), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus("after_abort", 64'h3, 2, 2, 0);

    // Back-to-back random traffic with random backpressure; the monitor
    // checks every result against the model.
    target = n_done + 3000;
    in_vld = 1'b1;
    for (int c = 0; c < 60000 && n_done < target; c++) begin
      @(posedge clk); #1;
      r  = {$urandom, $urandom};
      sh = $urandom_range(0, NC);
      if (sh == NC) r = '0;
      else r = r >> (CHUNK_W * sh);
      if ($urandom_range(0, 3) == 0) r = r & {$urandom, $urandom};
      in_dat  = r;
      out_rdy = ($urandom_range(0, 3) != 0);
    end
    checkOutput("random_completed", int'(n_done >= target), 1);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_busy", int'(busy), 0);
    checkOutput("drain_queue", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
